risc_instr_issuer: RTL and testbench

- Program sequencer feeding simple_risc_proc: owns a small program RAM, streams 16-bit instructions onto the processor's instr input, and captures each returned result into a result RAM.
- Sits between the test/host load interface and the processor; it is the driving end of the instr/result interface.
- Flags divide-by-zero results and reports completion with a one-cycle done pulse.

---
 rtl/risc_pkg.sv | 19 +
 rtl/risc_issuer_ram.sv | 18 +
 rtl/risc_instr_issuer.sv | 94 +++++++++
 tb/tb_risc_instr_issuer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: opcodes, instruction field slices and issuer FSM encoding shared by the issuer slice.
package risc_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OP1_MSB = 11;
  localparam int OP1_LSB = 6;
  localparam int OP2_MSB = 5;
  localparam int OP2_LSB = 0;
  localparam logic [15:0] DIV0_RESULT = 16'hFFFF;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  function automatic logic is_div0(input logic [15:0] w);
    return w[OPC_MSB:OPC_LSB] == OP_DIV && w[OP2_MSB:OP2_LSB] == '0;
  endfunction
endpackage

// File: rtl/risc_issuer_ram.sv
// risc_issuer_ram: single-write-port RAM with combinational read; contents are never reset.
module risc_issuer_ram #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/risc_instr_issuer.sv
// risc_instr_issuer: streams a stored program onto the processor instr port and captures
// each result LAT cycles later into a result RAM, counting divide-by-zero results.
module risc_instr_issuer
  import risc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [15:0]   instr,
  output logic          instr_valid,
  input  logic [15:0]   result_in,
  input  logic [AW-1:0] res_raddr,
  output logic [15:0]   res_rdata,
  output logic [AW:0]   div0_count
);
  localparam logic [AW:0] MAXC = (AW+1)'(DEPTH);
  state_t state;
  logic [AW:0] len, len_in;
  logic [AW-1:0] idx, prog_raddr;
  logic [15:0] prog_rdata;
  logic last, issue, drained;
  logic [LAT:0] pv, pdz;
  logic [LAT:0][AW-1:0] pidx;
  always_comb begin
    len_in = (prog_len > MAXC) ? MAXC : prog_len;
    last = ({1'b0, idx} + (AW+1)'(1)) == len;
    prog_raddr = (state == S_RUN) ? idx + AW'(1) : '0;
    issue = (state == S_IDLE && start && len_in != '0) || (state == S_RUN && !last);
    drained = ~|pv[LAT-1:0];
  end
  risc_issuer_ram #(.DEPTH(DEPTH), .AW(AW), .W(16)) u_prog (
    .clk(clk), .we(prog_we && state == S_IDLE), .waddr(prog_addr), .wdata(prog_data),
    .raddr(prog_raddr), .rdata(prog_rdata)
  );
  risc_issuer_ram #(.DEPTH(DEPTH), .AW(AW), .W(16)) u_res (
    .clk(clk), .we(pv[LAT]), .waddr(pidx[LAT]), .wdata(result_in),
    .raddr(res_raddr), .rdata(res_rdata)
  );
  // pipe stage 0 tracks the word currently on instr; stage LAT lines up with its result
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      instr <= '0;
      instr_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      div0_count <= '0;
      idx <= '0;
      len <= '0;
      pv <= '0;
      pdz <= '0;
      pidx <= '0;
    end else begin
      done <= 1'b0;
      pv <= {pv[LAT-1:0], issue};
      pdz <= {pdz[LAT-1:0], is_div0(prog_rdata)};
      pidx <= {pidx[LAT-1:0], prog_raddr};
      instr <= issue ? prog_rdata : '0;
      instr_valid <= issue;
      if (issue) idx <= prog_raddr;
      if (pv[LAT] && pdz[LAT] && result_in == DIV0_RESULT && div0_count != MAXC)
        div0_count <= div0_count + (AW+1)'(1);
      case (state)
        S_IDLE:
          if (start) begin
            len <= len_in;
            div0_count <= '0;
            busy <= 1'b1;
            done <= len_in == '0;
            state <= (len_in == '0) ? S_DONE : S_RUN;
          end
        S_RUN: if (last) state <= S_DRAIN;
        S_DRAIN:
          if (drained) begin
            done <= 1'b1;
            state <= S_DONE;
          end
        default: begin
          busy <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_risc_instr_issuer.sv
// tb_risc_instr_issuer: directed checks of the issuer against a one-cycle-latency processor model.
module tb_risc_instr_issuer;
  import risc_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [4:0] prog_len = '0;
  logic start = 1'b0;
  logic busy, done, instr_valid;
  logic [15:0] instr, res_rdata;
  logic [15:0] result_in = '0;
  logic [3:0] res_raddr = '0;
  logic [4:0] div0_count;
  int total = 0;
  int bad = 0;
  int nvalid, ndone, first_v, last_v, done_at, nbusy;
  logic [15:0] cap [32];

  risc_instr_issuer #(.DEPTH(16), .AW(4), .LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .busy(busy), .done(done),
    .instr(instr), .instr_valid(instr_valid), .result_in(result_in),
    .res_raddr(res_raddr), .res_rdata(res_rdata), .div0_count(div0_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] w(input logic [3:0] op, input int a, input int b);
    return {op, 6'(a), 6'(b)};
  endfunction

  function automatic logic [15:0] proc(input logic [15:0] i);
    logic [15:0] a, b;
    a = 16'(i[11:6]);
    b = 16'(i[5:0]);
    case (i[15:12])
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_MUL: return a * b;
      OP_DIV: return (b == 0) ? 16'hFFFF : a / b;
      default: return 16'h0000;
    endcase
  endfunction

  // processor stand-in: result of the word seen in cycle k is presented during cycle k+1
  always @(posedge clk) result_in <= proc(instr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [15:0] d);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 4'(a);
    prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic rd(input string tag, input int a, input logic [15:0] e);
    res_raddr = 4'(a);
    #1;
    chk(tag, res_rdata, e);
  endtask

  task automatic run(input int len, input int inj, input bit sw, input logic [15:0] swd);
    @(negedge clk);
    prog_len = 5'(len);
    start = 1'b1;
    if (sw) begin
      prog_we = 1'b1;
      prog_addr = 4'd0;
      prog_data = swd;
    end
    nvalid = 0; ndone = 0; first_v = -1; last_v = -1; done_at = -1; nbusy = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      start = 1'b0;
      prog_we = 1'b0;
      if (i == inj) begin
        start = 1'b1;
        prog_we = 1'b1;
        prog_addr = 4'd2;
        prog_data = w(OP_DIV, 5, 0);
      end
      if (instr_valid) begin
        if (nvalid < 32) cap[nvalid] = instr;
        if (nvalid == 0) first_v = i;
        last_v = i;
        nvalid++;
      end
      if (done) begin ndone++; done_at = i; end
      if (busy) nbusy++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_div0", div0_count, 0);
    reset_n = 1'b1;

    load(0, w(OP_ADD, 5, 3));
    load(1, w(OP_SUB, 10, 7));
    load(2, w(OP_MUL, 4, 2));
    load(3, w(OP_DIV, 9, 3));
    run(4, -1, 0, '0);
    chk("a_nvalid", nvalid, 4);
    chk("a_consec", last_v - first_v + 1, 4);
    chk("a_ndone", ndone, 1);
    chk("a_done_gap", done_at - last_v, 2);
    chk("a_nbusy", nbusy, 6);
    chk("a_cap0", cap[0], w(OP_ADD, 5, 3));
    chk("a_cap3", cap[3], w(OP_DIV, 9, 3));
    rd("a_res0", 0, 16'd8);
    rd("a_res1", 1, 16'd3);
    rd("a_res2", 2, 16'd8);
    rd("a_res3", 3, 16'd3);
    chk("a_div0", div0_count, 0);

    run(4, 2, 0, '0);
    chk("e_nvalid", nvalid, 4);
    chk("e_ndone", ndone, 1);
    chk("e_nbusy", nbusy, 6);
    run(4, -1, 0, '0);
    chk("e_prog2", cap[2], w(OP_MUL, 4, 2));
    rd("e_res2", 2, 16'd8);
    chk("e_div0", div0_count, 0);

    load(0, w(OP_DIV, 5, 0));
    load(1, w(OP_ADD, 1, 1));
    run(2, -1, 0, '0);
    chk("b_nvalid", nvalid, 2);
    rd("b_res0", 0, 16'hFFFF);
    rd("b_res1", 1, 16'd2);
    chk("b_div0", div0_count, 1);

    run(0, -1, 0, '0);
    chk("c_nvalid", nvalid, 0);
    chk("c_ndone", ndone, 1);
    chk("c_done_at", done_at, 1);
    chk("c_nbusy", nbusy, 1);
    chk("c_div0", div0_count, 0);

    for (int i = 0; i < 16; i++) load(i, w(OP_ADD, i, 1));
    run(20, -1, 0, '0);
    chk("d_nvalid", nvalid, 16);
    chk("d_consec", last_v - first_v + 1, 16);
    chk("d_cap15", cap[15], w(OP_ADD, 15, 1));
    chk("d_ndone", ndone, 1);
    chk("d_done_gap", done_at - last_v, 2);
    rd("d_res0", 0, 16'd1);
    rd("d_res15", 15, 16'd16);

    @(negedge clk);
    prog_len = 5'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("r_valid_c1", instr_valid, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("r_instr", instr, 0);
    chk("r_valid", instr_valid, 0);
    chk("r_busy", busy, 0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("r_no_done", ndone, 0);
    rd("r_res_kept", 0, 16'd1);
    run(4, -1, 0, '0);
    chk("r2_nvalid", nvalid, 4);
    chk("r2_cap0", cap[0], w(OP_ADD, 0, 1));
    chk("r2_ndone", ndone, 1);
    rd("r2_res3", 3, 16'd4);

    run(1, -1, 1, w(OP_SUB, 9, 4));
    chk("f_cap0_old", cap[0], w(OP_ADD, 0, 1));
    rd("f_res0_old", 0, 16'd1);
    run(1, -1, 0, '0);
    chk("f_cap0_new", cap[0], w(OP_SUB, 9, 4));
    rd("f_res0_new", 0, 16'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
